// File: rtl/stream_fifo_clearable.sv
// Single-clock DEPTH-entry valid/ready stream FIFO with a synchronous clear (drop or drain) and isolation cycle.
// Optional drop counter port drop_cnt_o is enabled by defining STREAM_FIFO_CLEAR_DROP_CNT_EN.
module stream_fifo_clearable #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned DRAIN_ON_CLEAR = 0,
  parameter int unsigned CNT_WIDTH      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  output logic                  clear_pending_o,
  output logic [CNT_WIDTH-1:0]  usage_o,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
`ifdef STREAM_FIFO_CLEAR_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt_o
`endif
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_ISOLATE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  cnt_after_pop;
  logic                  push, pop;
  logic                  drop_event;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    ptr_inc = (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : PTR_WIDTH'(p + PTR_WIDTH'(1));
  endfunction

  // Handshake status; ready_o sees clear_i combinationally so a clear never coincides with a push
  assign ready_o         = (cnt_q != CNT_WIDTH'(DEPTH)) && (state_q == ST_RUN) && !clear_i;
  assign valid_o         = (cnt_q != '0) && (state_q != ST_ISOLATE);
  assign push            = valid_i && ready_o;
  assign pop             = valid_o && ready_i;
  assign usage_o         = cnt_q;
  assign clear_pending_o = (state_q != ST_RUN);
  assign data_o          = mem[rd_ptr_q];
  assign cnt_after_pop   = cnt_q - CNT_WIDTH'(pop);

  // Next-state and pointer/count update
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d      = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    drop_event = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (clear_i) begin
          if (DRAIN_ON_CLEAR == 0) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            drop_event = 1'b1;
            state_d    = ST_ISOLATE;
          end else begin
            state_d = (cnt_after_pop != '0) ? ST_DRAIN : ST_ISOLATE;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_after_pop == '0) begin
          state_d = ST_ISOLATE;
        end
      end
      ST_ISOLATE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

`ifdef STREAM_FIFO_CLEAR_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic [16:0] drop_sum;

  assign drop_sum   = 17'(drop_cnt_q) + 17'(cnt_after_pop);
  assign drop_cnt_o = drop_cnt_q;

  // Saturating count of entries discarded by drop-mode clears
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (drop_event) begin
      drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop_event;
`endif

endmodule

// File: tb/tb_stream_fifo_clearable.sv
// Bench for stream_fifo_clearable: three instances (D4 drop, D3 drop, D4 drain) checked against a queue model.
module tb_stream_fifo_clearable;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_ISO   = 2;

  logic clk;
  logic rst;

  logic        vi [3];
  logic        ri [3];
  logic        ci [3];
  logic [31:0] di [3];

  logic        vo [3];
  logic        ro [3];
  logic        po [3];
  logic [31:0] dout [3];
  logic [2:0]  uo [3];
  logic [15:0] dc [3];

  logic        a_vo, a_ro, a_po, b_vo, b_ro, b_po, c_vo, c_ro, c_po;
  logic [31:0] a_do, b_do, c_do;
  logic [2:0]  a_uo, c_uo;
  logic [1:0]  b_uo;
  logic [15:0] a_dc, b_dc, c_dc;

  int n_cmp;
  int n_fail;
  int cyc;

  // Reference model (one FIFO at a time, selected per test)
  logic [31:0] q [$];
  int          st;
  int          dep;
  bit          drn;
  int          drop_m [3];

  stream_fifo_clearable #(.DATA_WIDTH(32), .DEPTH(4), .DRAIN_ON_CLEAR(0)) u_a (
    .clk_i(clk), .rst_i(rst), .clear_i(ci[0]), .clear_pending_o(a_po), .usage_o(a_uo),
    .valid_i(vi[0]), .ready_o(a_ro), .data_i(di[0]), .valid_o(a_vo), .ready_i(ri[0]), .data_o(a_do)
`ifdef STREAM_FIFO_CLEAR_DROP_CNT_EN
    , .drop_cnt_o(a_dc)
`endif
  );

  stream_fifo_clearable #(.DATA_WIDTH(32), .DEPTH(3), .DRAIN_ON_CLEAR(0)) u_b (
    .clk_i(clk), .rst_i(rst), .clear_i(ci[1]), .clear_pending_o(b_po), .usage_o(b_uo),
    .valid_i(vi[1]), .ready_o(b_ro), .data_i(di[1]), .valid_o(b_vo), .ready_i(ri[1]), .data_o(b_do)
`ifdef STREAM_FIFO_CLEAR_DROP_CNT_EN
    , .drop_cnt_o(b_dc)
`endif
  );

  stream_fifo_clearable #(.DATA_WIDTH(32), .DEPTH(4), .DRAIN_ON_CLEAR(1)) u_c (
    .clk_i(clk), .rst_i(rst), .clear_i(ci[2]), .clear_pending_o(c_po), .usage_o(c_uo),
    .valid_i(vi[2]), .ready_o(c_ro), .data_i(di[2]), .valid_o(c_vo), .ready_i(ri[2]), .data_o(c_do)
`ifdef STREAM_FIFO_CLEAR_DROP_CNT_EN
    , .drop_cnt_o(c_dc)
`endif
  );

`ifndef STREAM_FIFO_CLEAR_DROP_CNT_EN
  assign a_dc = '0;
  assign b_dc = '0;
  assign c_dc = '0;
`endif

  assign vo[0] = a_vo;  assign vo[1] = b_vo;  assign vo[2] = c_vo;
  assign ro[0] = a_ro;  assign ro[1] = b_ro;  assign ro[2] = c_ro;
  assign po[0] = a_po;  assign po[1] = b_po;  assign po[2] = c_po;
  assign dout[0] = a_do; assign dout[1] = b_do; assign dout[2] = c_do;
  assign uo[0] = a_uo;  assign uo[1] = 3'(b_uo); assign uo[2] = c_uo;
  assign dc[0] = a_dc;  assign dc[1] = b_dc;  assign dc[2] = c_dc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic sel(input int d);
    dep = (d == 1) ? 3 : 4;
    drn = (d == 2);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      vi[i] = 1'b0; ri[i] = 1'b0; ci[i] = 1'b0; di[i] = '0;
    end
  endtask

  // One clock of stimulus on instance d: check outputs mid-cycle, advance model, cross the edge
  task automatic step(input int d, input string tag);
    logic       ev, er, ep;
    logic [2:0] eu;
    bit         push, pop;
    int         n;
    n  = q.size();
    ev = (n != 0) && (st != M_ISO);
    er = (n != dep) && (st == M_RUN) && !ci[d];
    eu = (st == M_ISO) ? 3'd0 : 3'(n);
    ep = (st != M_RUN);
    #3;
    n_cmp += 4;
    if (vo[d] !== ev) begin
      n_fail++; $display("FAIL %s cyc%0d valid_o got %b exp %b", tag, cyc, vo[d], ev);
    end
    if (ro[d] !== er) begin
      n_fail++; $display("FAIL %s cyc%0d ready_o got %b exp %b", tag, cyc, ro[d], er);
    end
    if (uo[d] !== eu) begin
      n_fail++; $display("FAIL %s cyc%0d usage_o got %0d exp %0d", tag, cyc, uo[d], eu);
    end
    if (po[d] !== ep) begin
      n_fail++; $display("FAIL %s cyc%0d clear_pending_o got %b exp %b", tag, cyc, po[d], ep);
    end
    if (ev) begin
      n_cmp++;
      if (dout[d] !== q[0]) begin
        n_fail++; $display("FAIL %s cyc%0d data_o got %h exp %h", tag, cyc, dout[d], q[0]);
      end
    end
`ifdef STREAM_FIFO_CLEAR_DROP_CNT_EN
    n_cmp++;
    if (dc[d] !== 16'(drop_m[d])) begin
      n_fail++; $display("FAIL %s cyc%0d drop_cnt_o got %0d exp %0d", tag, cyc, dc[d], drop_m[d]);
    end
`endif
    push = vi[d] && er;
    pop  = ev && ri[d];
    if (pop) void'(q.pop_front());
    case (st)
      M_RUN: begin
        if (ci[d]) begin
          if (!drn) begin
            drop_m[d] = (drop_m[d] + q.size() > 65535) ? 65535 : drop_m[d] + q.size();
            q.delete();
            st = M_ISO;
          end else begin
            st = (q.size() != 0) ? M_DRAIN : M_ISO;
          end
        end else if (push) begin
          q.push_back(di[d]);
        end
      end
      M_DRAIN: if (q.size() == 0) st = M_ISO;
      default: st = M_RUN;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input int d, input string tag);
    vi[d] = 1'b0; ci[d] = 1'b0; ri[d] = 1'b1;
    repeat (dep + 3) step(d, tag);
  endtask

  task automatic test_reset();
    n_cmp += 3 * 5;
    for (int i = 0; i < 3; i++) begin
      if (vo[i] !== 1'b0) begin n_fail++; $display("FAIL reset valid_o[%0d] got %b exp 0", i, vo[i]); end
      if (ro[i] !== 1'b1) begin n_fail++; $display("FAIL reset ready_o[%0d] got %b exp 1", i, ro[i]); end
      if (uo[i] !== 3'd0) begin n_fail++; $display("FAIL reset usage_o[%0d] got %0d exp 0", i, uo[i]); end
      if (po[i] !== 1'b0) begin n_fail++; $display("FAIL reset clear_pending_o[%0d] got %b exp 0", i, po[i]); end
      if (dc[i] !== 16'd0) begin n_fail++; $display("FAIL reset drop_cnt[%0d] got %0d exp 0", i, dc[i]); end
    end
  endtask

  task automatic test_fill();
    sel(0);
    ri[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vi[0] = 1'b1; di[0] = 32'hA0 + 32'(i);
      step(0, "fill_push");
    end
    di[0] = 32'hEE;
    repeat (2) step(0, "fill_full");
    vi[0] = 1'b0; ri[0] = 1'b1;
    repeat (5) step(0, "fill_pop");
  endtask

  task automatic test_stream();
    sel(1);
    ri[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vi[1] = 1'b1; di[1] = 32'h100 + 32'(i);
      step(1, "stream");
    end
    flush(1, "stream_tail");
  endtask

  task automatic test_clear_drop();
    sel(0);
    ri[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vi[0] = 1'b1; di[0] = 32'hD0 + 32'(i);
      step(0, "drop_fill");
    end
    vi[0] = 1'b1; di[0] = 32'hBAD; ci[0] = 1'b1;
    step(0, "drop_clear");
    ci[0] = 1'b0; di[0] = 32'h77;
    repeat (3) step(0, "drop_after");
    flush(0, "drop_tail");
  endtask

  task automatic test_clear_drain();
    sel(2);
    ri[2] = 1'b0; vi[2] = 1'b1;
    di[2] = 32'h11; step(2, "drain_fill");
    di[2] = 32'h22; step(2, "drain_fill");
    di[2] = 32'h33; ci[2] = 1'b1; ri[2] = 1'b1;
    step(2, "drain_clear");
    ci[2] = 1'b0;
    repeat (4) step(2, "drain_run");
    flush(2, "drain_tail");
  endtask

  task automatic test_clear_empty();
    sel(2);
    vi[2] = 1'b0; ri[2] = 1'b1; ci[2] = 1'b1;
    step(2, "empty_clear");
    ci[2] = 1'b0;
    repeat (3) step(2, "empty_after");
  endtask

  task automatic test_reset_mid_drain();
    sel(2);
    ri[2] = 1'b0; vi[2] = 1'b1;
    di[2] = 32'h61; step(2, "rst_fill");
    di[2] = 32'h62; step(2, "rst_fill");
    vi[2] = 1'b0; ci[2] = 1'b1;
    step(2, "rst_clear");
    ci[2] = 1'b0;
    step(2, "rst_in_drain");
    #2 rst = 1'b1;
    #1;
    n_cmp += 4;
    if (uo[2] !== 3'd0) begin n_fail++; $display("FAIL rst_async usage_o got %0d exp 0", uo[2]); end
    if (vo[2] !== 1'b0) begin n_fail++; $display("FAIL rst_async valid_o got %b exp 0", vo[2]); end
    if (po[2] !== 1'b0) begin n_fail++; $display("FAIL rst_async clear_pending_o got %b exp 0", po[2]); end
    if (ro[2] !== 1'b1) begin n_fail++; $display("FAIL rst_async ready_o got %b exp 1", ro[2]); end
    #1 rst = 1'b0;
    q.delete();
    st = M_RUN;
    for (int i = 0; i < 3; i++) drop_m[i] = 0;
    @(posedge clk);
    #1;
    vi[2] = 1'b1; di[2] = 32'h55; ri[2] = 1'b1;
    step(2, "rst_push");
    vi[2] = 1'b0;
    repeat (3) step(2, "rst_pop");
  endtask

  task automatic test_random(input int d, input int cycles, input string tag);
    sel(d);
    for (int i = 0; i < cycles; i++) begin
      vi[d] = 1'($urandom_range(0, 1));
      ri[d] = ($urandom_range(0, 3) != 0);
      di[d] = $urandom;
      ci[d] = (st == M_RUN) && ($urandom_range(0, 15) == 0);
      step(d, tag);
    end
    flush(d, tag);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    st = M_RUN; dep = 4; drn = 1'b0;
    for (int i = 0; i < 3; i++) drop_m[i] = 0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    test_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    test_fill();
    test_stream();
    test_clear_drop();
    test_clear_drain();
    test_clear_empty();
    test_reset_mid_drain();
    test_random(1, 400, "rand_d3_drop");
    test_random(0, 300, "rand_d4_drop");
    test_random(2, 400, "rand_d4_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_fifo_clearable.md
Name: stream_fifo_clearable

Overview:
Single-clock, parametrised-depth stream FIFO with valid/ready handshakes on both sides and a synchronous clear with isolation.
- Successor to the team's clearable handshake buffering: generalises the single-entry 2-phase slot to DEPTH entries.
- Clear can either drop the contents or drain them first, selected by a mode parameter.
- Exposes clear-pending and fill-level status.
- Used as the local buffer in front of or behind CDC endpoints and in stream datapaths that need functional flushes.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=1).
- DEPTH, 4, number of entries (>=1, power of two not required).
- DRAIN_ON_CLEAR, 0, 0 = clear drops stored entries; 1 = clear blocks input and drains stored entries to the output before completing.
- CNT_WIDTH, $clog2(DEPTH+1), derived (do not override); width of usage_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- clear_i  in  1  synchronous clear request, one-cycle pulse.
- clear_pending_o  out  1  high while a clear sequence is in progress.
- usage_o  out  CNT_WIDTH  number of stored entries.
- valid_i  in  1  input valid.
- ready_o  out  1  input ready.
- data_i  in  DATA_WIDTH  input payload.
- valid_o  out  1  output valid.
- ready_i  in  1  output ready.
- data_o  out  DATA_WIDTH  output payload (head entry).

Behaviour:
- Reset (async, rst_i=1):
  - Pointers 0, usage_o=0, state RUN.
  - valid_o=0, ready_o=1 once state is RUN, clear_pending_o=0.
  - data_o undefined/don't-care; storage array has no reset.
- Handshakes:
  - Push when valid_i&&ready_o; pop when valid_o&&ready_i.
  - Once valid_o or valid_i is asserted, its data is held stable until accepted (bench checks output side).
- Latency: an entry pushed at edge N appears on valid_o/data_o after edge N (1 cycle); no fall-through path.
- ready_o = (usage_o != DEPTH) && state==RUN && !clear_i.
  - Full means no push even with a simultaneous pop.
  - ready_o depends combinationally on clear_i only.
- valid_o = (usage_o != 0) && state != ISOLATE.
- Simultaneous push and pop (not full, not empty): usage unchanged, both pointers advance.
- Pointers wrap from DEPTH-1 to 0, also for non-power-of-two DEPTH.
- State machine:
  - RUN: normal operation. On clear_i:
    - DRAIN_ON_CLEAR=0: at that edge, zero pointers and usage, then go to ISOLATE.
    - DRAIN_ON_CLEAR=1: go to DRAIN if usage would be nonzero after this edge's pop; otherwise go to ISOLATE.
  - DRAIN (DRAIN_ON_CLEAR=1 only): ready_o=0; output side operates normally. When the pop that empties the FIFO occurs, go to ISOLATE.
  - ISOLATE: exactly 1 cycle; ready_o=0, valid_o=0, usage_o=0; then go to RUN.
- clear_pending_o = state != RUN (registered, no clear_i path).
- clear_i while clear_pending_o=1: ignored (protocol violation; bench asserts it never happens).
- clear_i together with valid_i: no push occurs, because ready_o=0.
- Reset asserted mid-sequence (DRAIN or ISOLATE): immediate return to RUN with empty FIFO.

Optional Feature:
- Macro STREAM_FIFO_CLEAR_DROP_CNT_EN.
- When defined:
  - Adds output port drop_cnt_o, 16 bits, reset 0.
  - At each clear with DRAIN_ON_CLEAR=0, drop_cnt_o increments by the number of entries discarded (usage after that edge's pop), saturating at 16'hFFFF.
  - With DRAIN_ON_CLEAR=1 it stays 0.
- When undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Fill (DEPTH=4), ready_i=0: push 0xA0..0xA3 -> usage_o=4, ready_o=0; extra valid_i not accepted; then ready_i=1 pops 0xA0..0xA3 in order, one per cycle, usage_o back to 0.
- Streaming with ready_i=1, DEPTH=3: push 10 sequential words back-to-back -> each appears exactly 1 cycle after push, order preserved across pointer wrap, usage_o stays 1.
- DRAIN_ON_CLEAR=0, 3 entries stored, clear_i pulse -> next cycle clear_pending_o=1, valid_o=0, ready_o=0, usage_o=0; following cycle RUN, ready_o=1; no dropped word ever appears on data_o; with the macro defined, drop_cnt_o=3.
- DRAIN_ON_CLEAR=1, 2 entries (0x11, 0x22) stored, clear_i pulse with ready_i=1 -> ready_o=0 throughout; 0x11 then 0x22 popped; then 1 ISOLATE cycle; clear_pending_o high from the edge after clear_i until the RUN re-entry edge.
- DRAIN_ON_CLEAR=1, clear_i with FIFO empty -> exactly 1 cycle of clear_pending_o=1, then RUN.
- rst_i asserted asynchronously mid-DRAIN with 2 entries -> same cycle: usage_o=0, valid_o=0, clear_pending_o=0; after release, ready_o=1 and a new push of 0x55 is popped intact.
